// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } add_op_t;

  function automatic bit width_ok(int width, int stages);
    return (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple segment; also exposes the carry into its top bit
// so the final segment can form signed overflow.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum   = p ^ c[SEG-1:0];
    co    = c[SEG];
    c_msb = c[SEG-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple segments with registered
// inter-segment carries; whole pipeline stalls on output backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  add_op_t          op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  logic             advance;
  logic             unused_ok;

  assign out_valid = v_q[STAGES-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;

  assign s    = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = ovf_q;

  // Subtraction is folded in up front so every later stage is a plain adder.
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = (op == SUB) ? ~b : b;
    src_s[0] = '0;
    src_c[0] = (op == SUB) ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(.SEG(SEG)) u_seg (
      .a     (src_a[k][k*SEG +: SEG]),
      .b     (src_b[k][k*SEG +: SEG]),
      .ci    (src_c[k]),
      .sum   (seg_s[k]),
      .co    (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]                 <= src_v[k];
        a_q[k]                 <= src_a[k];
        b_q[k]                 <= src_b[k];
        s_q[k]                 <= src_s[k];
        s_q[k][k*SEG +: SEG]   <= seg_s[k];
        c_q[k]                 <= seg_co[k];
      end
      ovf_q <= seg_cm[STAGES-1] ^ seg_co[STAGES-1];
    end
  end

  // Final-stage operand copies have no consumer.
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 16/4 instance plus 4/1 and 4/2 instances against an
// arithmetic reference model.
module tb_pipelined_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;
  add_op_t     op;

  logic        p1_in_valid, p1_in_ready, p1_cin, p1_out_valid, p1_out_ready, p1_cout, p1_ovf;
  logic [3:0]  p1_a, p1_b, p1_s;
  add_op_t     p1_op;

  logic        p2_in_valid, p2_in_ready, p2_cin, p2_out_valid, p2_out_ready, p2_cout, p2_ovf;
  logic [3:0]  p2_a, p2_b, p2_s;
  add_op_t     p2_op;

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .a(p1_a), .b(p1_b), .cin(p1_cin), .op(p1_op), .out_valid(p1_out_valid),
    .out_ready(p1_out_ready), .s(p1_s), .cout(p1_cout), .ovf(p1_ovf)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) dut_s2 (
    .clk(clk), .reset(reset), .in_valid(p2_in_valid), .in_ready(p2_in_ready),
    .a(p2_a), .b(p2_b), .cin(p2_cin), .op(p2_op), .out_valid(p2_out_valid),
    .out_ready(p2_out_ready), .s(p2_s), .cout(p2_cout), .ovf(p2_ovf)
  );

  // Returns {ovf, cout, s[15:0]} from plain signed/unsigned arithmetic.
  function automatic logic [17:0] model(int w, longint ua, longint ub, bit c, bit sub);
    longint m, half, sa, sb, r, ures;
    bit co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (sub) begin
      r    = sa - sb;
      co   = (ua >= ub);
      ures = (ua - ub + m) % m;
    end else begin
      r    = sa + sb + longint'(c);
      ures = ua + ub + longint'(c);
      co   = (ures >= m);
      ures = ures % m;
    end
    ov = (r < -half) || (r >= half);
    return {ov, co, ures[15:0]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    p1_in_valid = 1'b0; p1_out_ready = 1'b0;
    p2_in_valid = 1'b0; p2_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (s !== 16'h0) begin bad++; $display("FAIL reset_s got=%h exp=0000", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_directed(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                               input add_op_t top, input logic [15:0] es, input logic ec,
                               input logic eo, input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; op = top; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != 4) begin bad++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
    total++; if (s !== es) begin bad++; $display("FAIL %s_s got=%h exp=%h", nm, s, es); end
    total++; if (cout !== ec) begin bad++; $display("FAIL %s_cout got=%b exp=%b", nm, cout, ec); end
    total++; if (ovf !== eo) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, eo); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] expq[$];
    logic [17:0] e;
    logic [15:0] held;
    int sent = 0, got = 0, cyc = 0, stall = 0;
    bit seen = 0;
    held = '0;
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      if (out_valid === 1'b1 && !seen) begin seen = 1; stall = 3; held = s; end
      out_ready = (stall == 0);
      in_valid  = (sent < 6);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      op = add_op_t'($urandom_range(0, 1));
      #1;
      if (stall > 0) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready got=%b exp=0", in_ready); end
        total++; if (s !== held) begin bad++; $display("FAIL b2b_stall_s_hold got=%h exp=%h", s, held); end
        stall--;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL b2b_extra_result got=%h exp=none", s);
        end else begin
          e = expq.pop_front();
          if ({ovf, cout, s} !== e) begin bad++; $display("FAIL b2b_result got=%h exp=%h", {ovf, cout, s}, e); end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        expq.push_back(model(16, longint'(a), longint'(b), cin, op == SUB));
        sent++;
      end
      cyc++;
    end
    total++; if (got != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_in_flight();
    int stale = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op = ADD;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rif_out_valid got=%b exp=0", out_valid); end
    total++; if (s !== 16'h0) begin bad++; $display("FAIL rif_s got=%h exp=0000", s); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rif_in_ready got=%b exp=1", in_ready); end
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rif_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_random_stream(input int n);
    logic [17:0] expq[$];
    logic [17:0] e;
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      op = add_op_t'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rand_extra_result got=%h exp=none", s);
        end else begin
          e = expq.pop_front();
          if ({ovf, cout, s} !== e) begin bad++; $display("FAIL rand_result got=%h exp=%h", {ovf, cout, s}, e); end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        expq.push_back(model(16, longint'(a), longint'(b), cin, op == SUB));
        sent++;
      end
      cyc++;
    end
    total++; if (got != n) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got, n); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_exhaustive_small();
    logic [5:0] q1[$], q2[$];
    logic [5:0] e;
    logic [17:0] m;
    int n1 = 0, n2 = 0, g1 = 0, g2 = 0, cyc = 0;
    while ((g1 < 1024 || g2 < 1024) && cyc < 10000) begin
      @(negedge clk);
      p1_in_valid = (n1 < 1024);
      p1_a = n1[3:0]; p1_b = n1[7:4]; p1_cin = n1[8]; p1_op = add_op_t'(n1[9]);
      p1_out_ready = ($urandom_range(0, 2) != 0);
      p2_in_valid = (n2 < 1024);
      p2_a = n2[3:0]; p2_b = n2[7:4]; p2_cin = n2[8]; p2_op = add_op_t'(n2[9]);
      p2_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (p1_out_valid === 1'b1 && p1_out_ready) begin
        total++;
        if (q1.size() == 0) begin
          bad++; $display("FAIL s1_extra_result got=%h exp=none", p1_s);
        end else begin
          e = q1.pop_front();
          if ({p1_ovf, p1_cout, p1_s} !== e) begin bad++; $display("FAIL s1_result got=%h exp=%h", {p1_ovf, p1_cout, p1_s}, e); end
        end
        g1++;
      end
      if (p2_out_valid === 1'b1 && p2_out_ready) begin
        total++;
        if (q2.size() == 0) begin
          bad++; $display("FAIL s2_extra_result got=%h exp=none", p2_s);
        end else begin
          e = q2.pop_front();
          if ({p2_ovf, p2_cout, p2_s} !== e) begin bad++; $display("FAIL s2_result got=%h exp=%h", {p2_ovf, p2_cout, p2_s}, e); end
        end
        g2++;
      end
      if (p1_in_valid && p1_in_ready === 1'b1) begin
        m = model(4, longint'(p1_a), longint'(p1_b), p1_cin, p1_op == SUB);
        q1.push_back({m[17], m[16], m[3:0]});
        n1++;
      end
      if (p2_in_valid && p2_in_ready === 1'b1) begin
        m = model(4, longint'(p2_a), longint'(p2_b), p2_cin, p2_op == SUB);
        q2.push_back({m[17], m[16], m[3:0]});
        n2++;
      end
      cyc++;
    end
    total++; if (g1 != 1024) begin bad++; $display("FAIL s1_count got=%0d exp=1024", g1); end
    total++; if (g2 != 1024) begin bad++; $display("FAIL s2_count got=%0d exp=1024", g2); end
    @(negedge clk);
    p1_in_valid = 1'b0; p2_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = ADD;
    p1_in_valid = 1'b0; p1_out_ready = 1'b0; p1_a = '0; p1_b = '0; p1_cin = 1'b0; p1_op = ADD;
    p2_in_valid = 1'b0; p2_out_ready = 1'b0; p2_a = '0; p2_b = '0; p2_cin = 1'b0; p2_op = ADD;

    test_reset();
    test_directed(16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b0, "add_wrap");
    test_directed(16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b1, "add_ovf");
    test_directed(16'h1234, 16'h1111, 1'b1, ADD, 16'h2346, 1'b0, 1'b0, "add_cin");
    test_directed(16'h0005, 16'h0007, 1'b0, SUB, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    test_directed(16'h8000, 16'h0001, 1'b0, SUB, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    test_back_to_back();
    test_reset_in_flight();
    test_random_stream(300);
    test_exhaustive_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
